// File: rtl/vga_timing_generator.sv
// -----------------------------------------------------------------------------
// vga_timing_generator
//
// Generates VGA raster timing with a sub-pixel phase counter. Each pixel is
// split into 2**SUB_PIXEL_WIDTH clock phases (0 text fetch, 1 glyph fetch,
// 2 wait, 3 draw). The pixel counter advances on the last phase, and the line
// counter advances when the pixel counter wraps. The visible, hsync and vsync
// flags are registered and decoded from the next-state counters, so they line
// up with the counter outputs in the same cycle without glitches.
//
// Ports
//   clk           : clock, all state changes on the rising edge
//   reset         : synchronous, active-high; takes priority over enable
//   enable        : advance timing when high, hold everything when low
//   pixel_state   : sub-pixel phase
//   pixel_counter : horizontal pixel position, 0 .. H_TOTAL-1
//   line_counter  : low 9 bits of the internal 10-bit line count
//   visible       : position lies inside the active area
//   hsync, vsync  : sync pulses, active at SYNC_POL
//   frame_start   : one-cycle pulse on the first cycle at the frame origin
//                   after a natural wrap (never after reset)
// -----------------------------------------------------------------------------
module vga_timing_generator #(
    parameter int SUB_PIXEL_WIDTH = 2,
    parameter int H_VISIBLE       = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter bit SYNC_POL        = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    output logic [SUB_PIXEL_WIDTH-1:0] pixel_state,
    output logic [9:0]                 pixel_counter,
    output logic [8:0]                 line_counter,
    output logic                       visible,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [SUB_PIXEL_WIDTH-1:0] PS_LAST = '1;
    localparam logic [SUB_PIXEL_WIDTH-1:0] PS_ONE  = SUB_PIXEL_WIDTH'(1);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    // Full 10-bit line count; only the low 9 bits leave the block, so lines
    // 512..524 alias onto 0..12 on line_counter.
    logic [9:0] line_q;

    logic [SUB_PIXEL_WIDTH-1:0] ps_next;
    logic [9:0]                 px_next;
    logic [9:0]                 ln_next;
    logic                       frame_wrap;

    assign line_counter = line_q[8:0];

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        ps_next    = pixel_state;
        px_next    = pixel_counter;
        ln_next    = line_q;
        frame_wrap = 1'b0;
        if (enable) begin
            ps_next = pixel_state + PS_ONE;
            if (pixel_state == PS_LAST) begin
                if (pixel_counter == H_LAST) begin
                    px_next = '0;
                    if (line_q == V_LAST) begin
                        ln_next    = '0;
                        frame_wrap = 1'b1;
                    end else begin
                        ln_next = line_q + 10'd1;
                    end
                end else begin
                    px_next = pixel_counter + 10'd1;
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; reset is synchronous and checked before enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_state   <= '0;
            pixel_counter <= '0;
            line_q        <= '0;
            visible       <= 1'b1;
            hsync         <= ~SYNC_POL;
            vsync         <= ~SYNC_POL;
            frame_start   <= 1'b0;
        end else begin
            pixel_state   <= ps_next;
            pixel_counter <= px_next;
            line_q        <= ln_next;
            // Decoding the next-state counters keeps the flags aligned with
            // the counters; with enable low the counters hold, so do these.
            visible       <= (px_next < H_VIS_END) && (ln_next < V_VIS_END);
            hsync         <= ((px_next >= H_SYNC_START) && (px_next < H_SYNC_END))
                             ? SYNC_POL : ~SYNC_POL;
            vsync         <= ((ln_next >= V_SYNC_START) && (ln_next < V_SYNC_END))
                             ? SYNC_POL : ~SYNC_POL;
            frame_start   <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_generator
//
// Two instances share one clock: dut_a uses the default 800x525 timing,
// dut_b keeps the default vertical timing but a short 8-pixel line so whole
// frames (16,800 clocks instead of 1,680,000) fit in a short run. A reference
// model tracks each instance as a single linear tick count inside the frame
// and derives every output from it with plain arithmetic.
//
// Output snapshots are packed as {ps[24:23], px[22:13], lc[12:4], vis[3],
// hs[2], vs[1], fs[0]}.
// -----------------------------------------------------------------------------
module tb_vga_timing_generator;

    typedef struct {
        int hv, hfp, hsw, hbp;
        int vv, vfp, vsw, vbp;
    } timing_t;

    localparam timing_t TA = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam timing_t TB = '{4, 1, 2, 1, 480, 10, 2, 33};

    typedef struct {
        bit en;
        int ps;
        int px;
        bit vis;
        bit hs;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, en_a = 1'b0;
    logic       rst_b = 1'b1, en_b = 1'b0;
    logic [1:0] ps_a, ps_b;
    logic [9:0] px_a, px_b;
    logic [8:0] lc_a, lc_b;
    logic       vis_a, hs_a, vs_a, fs_a;
    logic       vis_b, hs_b, vs_b, fs_b;

    vga_timing_generator dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a),
        .pixel_state(ps_a), .pixel_counter(px_a), .line_counter(lc_a),
        .visible(vis_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
    );

    vga_timing_generator #(
        .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)
    ) dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b),
        .pixel_state(ps_b), .pixel_counter(px_b), .line_counter(lc_b),
        .visible(vis_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pk(input logic [1:0] ps, input logic [9:0] px,
                                       input logic [8:0] lc, input logic vis,
                                       input logic hs, input logic vs, input logic fs);
        return {7'd0, ps, px, lc, vis, hs, vs, fs};
    endfunction

    function automatic logic [31:0] cur(input bit sel);
        if (sel) return pk(ps_b, px_b, lc_b, vis_b, hs_b, vs_b, fs_b);
        return pk(ps_a, px_a, lc_a, vis_a, hs_a, vs_a, fs_a);
    endfunction

    function automatic int frame_ticks(input timing_t p);
        return 4 * (p.hv + p.hfp + p.hsw + p.hbp) * (p.vv + p.vfp + p.vsw + p.vbp);
    endfunction

    // Expected outputs for tick t of the frame (t = 0 is the origin).
    function automatic logic [31:0] model_out(input timing_t p, input int t, input bit fs);
        int  ht, vt, ps, px, ln;
        bit  vis, hs, vs;
        ht  = p.hv + p.hfp + p.hsw + p.hbp;
        vt  = p.vv + p.vfp + p.vsw + p.vbp;
        ps  = t % 4;
        px  = (t / 4) % ht;
        ln  = (t / (4 * ht)) % vt;
        vis = (px < p.hv) && (ln < p.vv);
        hs  = !((px >= p.hv + p.hfp) && (px < p.hv + p.hfp + p.hsw));
        vs  = !((ln >= p.vv + p.vfp) && (ln < p.vv + p.vfp + p.vsw));
        return pk(2'(ps), 10'(px), 9'(ln % 512), vis, hs, vs, fs);
    endfunction

    // Reference model: advanced on each rising edge from the applied inputs,
    // compared against both instances 1 time unit later.
    int t_a = 0, t_b = 0;
    bit mfs_a = 1'b0, mfs_b = 1'b0;
    bit armed_a = 1'b0, armed_b = 1'b0;

    always @(posedge clk) begin
        if (rst_a) begin
            t_a = 0; mfs_a = 1'b0; armed_a = 1'b1;
        end else if (en_a) begin
            t_a = (t_a + 1) % frame_ticks(TA); mfs_a = (t_a == 0);
        end else begin
            mfs_a = 1'b0;
        end
        if (rst_b) begin
            t_b = 0; mfs_b = 1'b0; armed_b = 1'b1;
        end else if (en_b) begin
            t_b = (t_b + 1) % frame_ticks(TB); mfs_b = (t_b == 0);
        end else begin
            mfs_b = 1'b0;
        end
        #1;
        if (armed_a) check("model_a", cur(1'b0), model_out(TA, t_a, mfs_a));
        if (armed_b) check("model_b", cur(1'b1), model_out(TB, t_b, mfs_b));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until the instance shows (ps, px[, lc]); lc < 0 means any line.
    task automatic wait_pos(input bit sel, input int ps, input int px, input int lc,
                            input int budget, input string name);
        logic [31:0] c;
        bit found = 1'b0;
        for (int n = 0; n < budget; n++) begin
            c = cur(sel);
            if (int'(c[24:23]) == ps && int'(c[22:13]) == px &&
                (lc < 0 || int'(c[12:4]) == lc)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check({name, "_reached"}, {31'd0, found}, 32'd1);
    endtask

    task automatic run_a();
        vec_t tab[8];
        logic [31:0] c;
        tab = '{'{1, 0, 0, 1, 1}, '{1, 1, 0, 1, 1}, '{1, 2, 0, 1, 1}, '{1, 3, 0, 1, 1},
                '{0, 0, 1, 1, 1}, '{0, 0, 1, 1, 1}, '{1, 0, 1, 1, 1}, '{1, 1, 1, 1, 1}};

        rst_a = 1'b1; en_a = 1'b0;
        step();
        rst_a = 1'b0;
        check("a_reset_state", cur(1'b0), pk(2'd0, 10'd0, 9'd0, 1, 1, 1, 0));

        // Row i: expected outputs now, then the enable applied for the next edge.
        for (int i = 0; i < 8; i++) begin
            c = cur(1'b0);
            check($sformatf("a_tab%0d_ps", i),  {30'd0, c[24:23]}, 32'(tab[i].ps));
            check($sformatf("a_tab%0d_px", i),  {22'd0, c[22:13]}, 32'(tab[i].px));
            check($sformatf("a_tab%0d_vis", i), {31'd0, c[3]},     {31'd0, tab[i].vis});
            check($sformatf("a_tab%0d_hs", i),  {31'd0, c[2]},     {31'd0, tab[i].hs});
            en_a = tab[i].en;
            step();
        end

        en_a = 1'b1;
        wait_pos(1'b0, 3, 639, 0, 4000, "a_px639");
        step();
        check("a_px640_px",  32'(px_a), 32'd640);
        check("a_px640_vis", {31'd0, vis_a}, 32'd0);

        wait_pos(1'b0, 3, 655, 0, 200, "a_px655");
        step();
        check("a_px656_px", 32'(px_a), 32'd656);
        check("a_px656_hs", {31'd0, hs_a}, 32'd0);

        wait_pos(1'b0, 3, 751, 0, 600, "a_px751");
        step();
        check("a_px752", cur(1'b0), pk(2'd0, 10'd752, 9'd0, 0, 1, 1, 0));

        // Freeze mid-line for three clocks.
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("a_freeze%0d", i), cur(1'b0), pk(2'd0, 10'd752, 9'd0, 0, 1, 1, 0));
        end
        en_a = 1'b1;
        step();
        check("a_unfreeze", cur(1'b0), pk(2'd1, 10'd752, 9'd0, 0, 1, 1, 0));

        wait_pos(1'b0, 3, 799, 0, 400, "a_px799");
        check("a_px799_vis", {31'd0, vis_a}, 32'd0);

        wait_pos(1'b0, 3, 799, 10, 40000, "a_line10_end");
        step();
        check("a_line11_start", cur(1'b0), pk(2'd0, 10'd0, 9'd11, 1, 1, 1, 0));

        for (int i = 0; i < 3000; i++) begin
            en_a  = ($urandom_range(0, 3) != 0);
            rst_a = ($urandom_range(0, 299) == 0);
            step();
        end
        rst_a = 1'b0;
    endtask

    task automatic run_b();
        int fs_at[$];
        int cyc = 0, vs_cyc = 0, vs_min = 9999, vs_max = -1, n512 = 0;
        logic [31:0] prev, c;

        rst_b = 1'b1; en_b = 1'b0;
        step();
        rst_b = 1'b0; en_b = 1'b1;
        wait_pos(1'b1, 0, 0, 300, 12000, "b_line300");

        // Reset for one cycle mid-frame with enable still high.
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        check("b_reset_midframe", cur(1'b1), pk(2'd0, 10'd0, 9'd0, 1, 1, 1, 0));

        // Two full frames from the origin.
        prev = cur(1'b1);
        while (fs_at.size() < 2 && cyc < 40000) begin
            step();
            cyc++;
            c = cur(1'b1);
            if (prev[0]) check("b_fs_single", {31'd0, c[0]}, 32'd0);
            if (c[0]) begin
                fs_at.push_back(cyc);
                check("b_before_wrap", prev, pk(2'd3, 10'd7, 9'd12, 0, 1, 1, 0));
                check("b_origin_fs", c, pk(2'd0, 10'd0, 9'd0, 1, 1, 1, 1));
            end
            if (!c[1]) begin
                vs_cyc++;
                if (int'(c[12:4]) < vs_min) vs_min = int'(c[12:4]);
                if (int'(c[12:4]) > vs_max) vs_max = int'(c[12:4]);
            end
            if (prev[12:4] == 9'd511 && c[12:4] == 9'd0) begin
                n512++;
                check("b_line512_vis", {31'd0, c[3]}, 32'd0);
            end
            prev = c;
        end
        check("b_fs_count", 32'(fs_at.size()), 32'd2);
        if (fs_at.size() == 2) begin
            check("b_first_fs_cycle", 32'(fs_at[0]), 32'd16800);
            check("b_fs_spacing", 32'(fs_at[1] - fs_at[0]), 32'd16800);
        end
        check("b_vsync_cycles", 32'(vs_cyc), 32'd128);
        check("b_vsync_first_line", 32'(vs_min), 32'd490);
        check("b_vsync_last_line", 32'(vs_max), 32'd491);
        check("b_line512_seen", 32'(n512), 32'd2);

        // Freeze at the origin cycle: counters hold, frame_start drops.
        en_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("b_origin_freeze%0d", i), cur(1'b1), pk(2'd0, 10'd0, 9'd0, 1, 1, 1, 0));
        end
        en_b = 1'b1;
        step();
        check("b_origin_resume", cur(1'b1), pk(2'd1, 10'd0, 9'd0, 1, 1, 1, 0));

        for (int i = 0; i < 3000; i++) begin
            en_b  = ($urandom_range(0, 3) != 0);
            rst_b = ($urandom_range(0, 299) == 0);
            step();
        end
        rst_b = 1'b0;
    endtask

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            run_a();
            run_b();
        join
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

Interface
REQ-001 The module SHALL have parameter SUB_PIXEL_WIDTH, default 2, the sub-pixel phase counter width (4 clocks per pixel).
REQ-002 The module SHALL have parameters H_VISIBLE 640, H_FP 16, H_SYNC 96, H_BP 48, each a pixel count for one horizontal region.
REQ-003 The module SHALL have parameters V_VISIBLE 480, V_FP 10, V_SYNC 2, V_BP 33, each a line count for one vertical region.
REQ-004 The module SHALL have parameter SYNC_POL, default 0, the active level of hsync/vsync.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port enable, input, 1 bit: advance timing when high, freeze when low.
REQ-008 The module SHALL have port pixel_state, output, SUB_PIXEL_WIDTH bits: sub-pixel phase (0 text fetch, 1 glyph fetch, 2 wait, 3 draw).
REQ-009 The module SHALL have port pixel_counter, output, 10 bits: horizontal pixel position, 0..799.
REQ-010 The module SHALL have port line_counter, output, 9 bits: low 9 bits of the internal 10-bit line count (0..524).
REQ-011 The module SHALL have port visible, output, 1 bit: current position is inside the 640x480 active area.
REQ-012 The module SHALL have ports hsync and vsync, outputs, 1 bit each: sync pulses at SYNC_POL level.
REQ-013 The module SHALL have port frame_start, output, 1 bit: single-cycle pulse at frame origin.

Function
REQ-014 With enable high, pixel_state SHALL increment by 1 each clock, wrapping 3->0.
REQ-015 pixel_counter SHALL increment only in a cycle where enable is high and pixel_state is 3, wrapping H_TOTAL-1 (799) -> 0.
REQ-016 The internal line count SHALL increment only when pixel_counter wraps, and SHALL wrap V_TOTAL-1 (524) -> 0; H_TOTAL and V_TOTAL are the sums of their four region parameters.
REQ-017 With enable low, every counter, visible, hsync and vsync SHALL hold their values, and frame_start SHALL be 0.
REQ-018 visible SHALL equal (pixel_counter < H_VISIBLE) AND (internal line < V_VISIBLE).
REQ-019 hsync SHALL be at SYNC_POL for pixels H_VISIBLE+H_FP .. H_VISIBLE+H_FP+H_SYNC-1 (656..751), and at !SYNC_POL otherwise.
REQ-020 vsync SHALL be at SYNC_POL for internal lines 490..491, and at !SYNC_POL otherwise.
REQ-021 visible, hsync and vsync SHALL be registers decoded from next-state counters, so each matches the counter outputs of the same cycle (zero relative latency, glitch-free).
REQ-022 frame_start SHALL be 1 for exactly one cycle: the first cycle the counters show (0,0,0) after a wrap from (3,799,524); a reset does not produce it.
REQ-023 In internal lines 512..524, line_counter SHALL show 0..12 (truncation) while visible is 0.
REQ-024 Reset SHALL take priority over enable.

Reset
REQ-025 While reset is high at a clock edge, the next cycle SHALL show: pixel_state 0, pixel_counter 0, internal line 0, visible 1, hsync = vsync = !SYNC_POL, frame_start 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no partial sync pulse extension; timing restarts at the origin on the first enabled cycle after release.

Verification
REQ-027 Bench SHALL cover: reset, then enable high for 5 clocks -> pixel_state 0,1,2,3,0; pixel_counter 0 then 1 on the 5th cycle; visible 1 throughout.
REQ-028 Bench SHALL cover: run to pixel 655 with pixel_state 3 -> next cycle pixel 656, hsync 0; hsync returns to 1 at pixel 752; visible 0 from pixel 640 to 799.
REQ-029 Bench SHALL cover: pixel 799, pixel_state 3, line 10 -> next cycle pixel 0, line_counter 11, visible 1.
REQ-030 Bench SHALL cover a full frame -> vsync 0 on lines 490-491 only; internal line 512 shows line_counter 0 with visible 0; after (3,799,524) all counters 0 and frame_start 1 for one cycle; frame_start spacing 1,680,000 clocks.
REQ-031 Bench SHALL cover: enable low for 3 clocks mid-line and at the origin cycle -> all outputs frozen; frame_start not re-asserted.
REQ-032 Bench SHALL cover: reset high for one cycle at line 300 with enable high -> next cycle pixel_state 0, pixel_counter 0, line_counter 0, visible 1, syncs 1, frame_start 0.
